// File: rtl/regfile_wb.sv
// regfile_wb: 32-entry integer register file with per-register busy scoreboard.
// Consumer end of the writeback interface; two combinational read ports for
// decode/execute plus busy flags for RAW stall detection. x0 reads zero and is
// never busy.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-through of
// wb_wdata and retire-clear of the busy flag on the read ports.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module regfile_wb #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  wb_retire,
  input  logic                  iss_valid,
  input  logic [4:0]            iss_rd,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2,
  output logic                  busy1,
  output logic                  busy2,
  output logic [5:0]            busy_count
);

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CNT_W     = 6;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [CNT_W-1:0]      busy_count_q;
  logic [CNT_W-1:0]      busy_count_d;

  logic                  wr_en;
  logic                  clr_en;
  logic                  set_en;

  logic [DATA_WIDTH-1:0] rd1_stored;
  logic [DATA_WIDTH-1:0] rd2_stored;
  logic                  bz1_stored;
  logic                  bz2_stored;

  // Number of set bits in a busy vector.
  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      acc = acc + CNT_W'(v[i]);
    end
    return acc;
  endfunction

  // x0 gating of write, retire-clear and issue-set, re-applied locally.
  always_comb begin
    wr_en  = wb_we     && (wb_rd  != IDX_W'(0));
    clr_en = wb_retire && (wb_rd  != IDX_W'(0));
    set_en = iss_valid && (iss_rd != IDX_W'(0));
  end

  // Next busy vector: clear first, then set, so a new producer wins a tie.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[wb_rd] = 1'b0;
    end
    if (set_en) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
    busy_count_d = popcount(busy_d);
  end

  // Register array write; reset clears every entry and drops the write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wb_rd] <= wb_wdata;
    end
  end

  // Busy scoreboard and its registered population count.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  // Stored-state read, with x0 forced to zero / not busy.
  always_comb begin
    rd1_stored = (raddr1 == IDX_W'(0)) ? '0 : regs_q[raddr1];
    rd2_stored = (raddr2 == IDX_W'(0)) ? '0 : regs_q[raddr2];
    bz1_stored = (raddr1 == IDX_W'(0)) ? 1'b0 : busy_q[raddr1];
    bz2_stored = (raddr2 == IDX_W'(0)) ? 1'b0 : busy_q[raddr2];
  end

`ifdef REGFILE_BYPASS_EN
  logic byp_data1;
  logic byp_data2;
  logic byp_clr1;
  logic byp_clr2;
  logic iss_same;

  // Same-cycle write-through and retire-clear, suppressed while in reset.
  always_comb begin
    iss_same  = set_en && (iss_rd == wb_rd);
    byp_data1 = !rst && wr_en  && (raddr1 == wb_rd);
    byp_data2 = !rst && wr_en  && (raddr2 == wb_rd);
    byp_clr1  = !rst && clr_en && !iss_same && (raddr1 == wb_rd);
    byp_clr2  = !rst && clr_en && !iss_same && (raddr2 == wb_rd);
    rdata1    = byp_data1 ? wb_wdata : rd1_stored;
    rdata2    = byp_data2 ? wb_wdata : rd2_stored;
    busy1     = byp_clr1 ? 1'b0 : bz1_stored;
    busy2     = byp_clr2 ? 1'b0 : bz2_stored;
  end
`else
  // Reads see only committed state; a write is visible the following cycle.
  always_comb begin
    rdata1 = rd1_stored;
    rdata2 = rd2_stored;
    busy1  = bz1_stored;
    busy2  = bz2_stored;
  end
`endif

  assign busy_count = busy_count_q;

endmodule
